// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the RV32 pipeline front end.
package pipeline_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding buffer for responses that arrive while IF/ID is stalled.
module fetch_skid_buffer
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic         clear,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);

  logic         valid_q, valid_d;
  fetch_entry_t data_q, data_d;

  // A load in the same cycle as an unload refills the entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = din;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign dout  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/gnt/rvalid to imem, feeds IF/ID.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        PCSrc_E,
  input  logic [31:0] PCTarget_E,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PCPlus4_F,
  output logic        fetch_valid_F,
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         slot_v_q, slot_v_d;
  logic [31:0]  slot_instr_q, slot_instr_d;
  logic [31:0]  slot_pc_q, slot_pc_d;
  logic [31:0]  slot_pc4_q, slot_pc4_d;

  logic         skid_v, skid_load, skid_unload, skid_clear;
  fetch_entry_t skid_dout, rsp_entry;

  logic slot_free, rsp_v, rsp_to_slot, gnt_acc;

  assign slot_free   = !slot_v_q || !stall_F;
  assign rsp_v       = (state_q == WAIT) && imem_rvalid;
  assign rsp_to_slot = rsp_v && slot_free && !skid_v;
  assign gnt_acc     = imem_req && imem_gnt;
  assign rsp_entry   = '{instr: imem_rdata, pc: req_pc_q};

  fetch_skid_buffer u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (rsp_entry),
    .valid  (skid_v),
    .dout   (skid_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ISSUE;
    else       state_q <= state_d;
  end

  // A redirect leaves DROP behind only when a request is still in flight after this edge.
  always_comb begin
    state_d = state_q;
    if (PCSrc_E) begin
      state_d = (gnt_acc || (state_q != ISSUE && !imem_rvalid)) ? DROP : ISSUE;
    end else begin
      case (state_q)
        ISSUE:   if (gnt_acc) state_d = WAIT;
        WAIT:    if (imem_rvalid) state_d = gnt_acc ? WAIT : ISSUE;
        DROP:    if (imem_rvalid) state_d = ISSUE;
        default: state_d = ISSUE;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      ISSUE:   imem_req = !skid_v && !PCSrc_E;
      WAIT:    imem_req = rsp_to_slot && !PCSrc_E;
      default: imem_req = 1'b0;
    endcase
    if (reset) imem_req = 1'b0;
  end

  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    slot_v_d     = slot_v_q;
    slot_instr_d = slot_instr_q;
    slot_pc_d    = slot_pc_q;
    slot_pc4_d   = slot_pc4_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;
    if (PCSrc_E) begin
      pc_d       = PCTarget_E & ~32'h3;
      slot_v_d   = 1'b0;
      skid_clear = 1'b1;
    end else begin
      if (gnt_acc) begin
        req_pc_d = pc_q;
        pc_d     = pc_plus4(pc_q);
      end
      // Skid content is older than any new response, so it refills the slot first.
      if (slot_free) begin
        if (skid_v) begin
          slot_v_d     = 1'b1;
          slot_instr_d = skid_dout.instr;
          slot_pc_d    = skid_dout.pc;
          slot_pc4_d   = pc_plus4(skid_dout.pc);
          skid_unload  = 1'b1;
          skid_load    = rsp_v;
        end else if (rsp_v) begin
          slot_v_d     = 1'b1;
          slot_instr_d = imem_rdata;
          slot_pc_d    = req_pc_q;
          slot_pc4_d   = pc_plus4(req_pc_q);
        end else begin
          slot_v_d = 1'b0;
        end
      end else if (rsp_v) begin
        skid_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      slot_v_q     <= 1'b0;
      slot_instr_q <= '0;
      slot_pc_q    <= '0;
      slot_pc4_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      slot_v_q     <= slot_v_d;
      slot_instr_q <= slot_instr_d;
      slot_pc_q    <= slot_pc_d;
      slot_pc4_q   <= slot_pc4_d;
    end
  end

  assign imem_addr     = pc_q;
  assign instr_F       = slot_v_q ? slot_instr_q : NOP_INSTR;
  assign PC_F          = slot_pc_q;
  assign PCPlus4_F     = slot_pc4_q;
  assign fetch_valid_F = slot_v_q;
  assign fetch_busy    = !slot_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-outstanding imem responder model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall_F, PCSrc_E;
  logic [31:0] PCTarget_E;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr_F, PC_F, PCPlus4_F;
  logic        fetch_valid_F, fetch_busy;

  int checks = 0;
  int passed = 0;

  logic        hold_rsp = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_F(instr_F), .PC_F(PC_F), .PCPlus4_F(PCPlus4_F),
    .fetch_valid_F(fetch_valid_F), .fetch_busy(fetch_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0001;
  endfunction

  // One clock: note the handshake, cross the edge, then present the memory response.
  task automatic cycle();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = imem_req && imem_gnt;
    a  = imem_addr;
    @(posedge clk);
    #1;
    if (hs) begin pend = 1'b1; pend_addr = a; end
    if (pend && !hold_rsp) begin
      imem_rvalid = 1'b1; imem_rdata = instr_of(pend_addr); pend = 1'b0;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall_F = 1'b0; PCSrc_E = 1'b0; PCTarget_E = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; hold_rsp = 1'b0; pend = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_F = 1'b0; PCSrc_E = 1'b0; PCTarget_E = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    #2;
    checks++; if (instr_F !== NOP) $display("FAIL reset_instr got=%h exp=%h", instr_F, NOP); else passed++;
    checks++; if ({PC_F, PCPlus4_F} !== 64'h0) $display("FAIL reset_pc got=%h/%h exp=0/0", PC_F, PCPlus4_F); else passed++;
    checks++; if ({fetch_valid_F, fetch_busy} !== 2'b01) $display("FAIL reset_valid got=%b%b exp=01", fetch_valid_F, fetch_busy); else passed++;
    @(posedge clk); #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL stream_first_req got=%b/%h exp=1/0", imem_req, imem_addr); else passed++;
    cycle();
    checks++; if (imem_addr !== 32'h4) $display("FAIL stream_addr1 got=%h exp=4", imem_addr); else passed++;
    for (int i = 0; i < 4; i++) begin
      cycle();
      e = 32'(4 * i);
      checks++; if (PC_F !== e) $display("FAIL stream_pc got=%h exp=%h", PC_F, e); else passed++;
      checks++; if ({instr_F, PCPlus4_F, fetch_valid_F} !== {instr_of(e), e + 32'd4, 1'b1})
        $display("FAIL stream_slot got=%h/%h/%b exp=%h/%h/1", instr_F, PCPlus4_F, fetch_valid_F, instr_of(e), e + 32'd4); else passed++;
      checks++; if (imem_addr !== e + 32'd8) $display("FAIL stream_addr got=%h exp=%h", imem_addr, e + 32'd8); else passed++;
    end
  endtask

  task automatic test_stall_skid();
    do_reset();
    cycle(); cycle(); cycle();
    stall_F = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL stall_req_rsp got=%b exp=0", imem_req); else passed++;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if ({PC_F, instr_F, fetch_valid_F, imem_req} !== {32'h4, instr_of(32'h4), 1'b1, 1'b0})
        $display("FAIL stall_hold got=%h/%h/%b/%b exp=4/%h/1/0", PC_F, instr_F, fetch_valid_F, imem_req, instr_of(32'h4)); else passed++;
    end
    stall_F = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL stall_skid_req got=%b exp=0", imem_req); else passed++;
    cycle();
    checks++; if ({PC_F, instr_F, fetch_valid_F} !== {32'h8, instr_of(32'h8), 1'b1})
      $display("FAIL stall_skid_out got=%h/%h/%b exp=8/%h/1", PC_F, instr_F, fetch_valid_F, instr_of(32'h8)); else passed++;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) $display("FAIL stall_resume_req got=%b/%h exp=1/c", imem_req, imem_addr); else passed++;
    cycle();
    checks++; if ({fetch_valid_F, instr_F} !== {1'b0, NOP}) $display("FAIL stall_bubble got=%b/%h exp=0/%h", fetch_valid_F, instr_F, NOP); else passed++;
    cycle();
    checks++; if ({PC_F, instr_F, fetch_valid_F} !== {32'hC, instr_of(32'hC), 1'b1})
      $display("FAIL stall_next got=%h/%h/%b exp=c/%h/1", PC_F, instr_F, fetch_valid_F, instr_of(32'hC)); else passed++;
  endtask

  task automatic test_redirect_drop();
    do_reset();
    cycle(); cycle(); cycle(); cycle();
    hold_rsp = 1'b1;
    cycle();
    checks++; if (PC_F !== 32'hC) $display("FAIL drop_pre_pc got=%h exp=c", PC_F); else passed++;
    PCSrc_E = 1'b1; PCTarget_E = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL drop_redirect_req got=%b exp=0", imem_req); else passed++;
    cycle();
    PCSrc_E = 1'b0;
    #1;
    checks++; if ({fetch_valid_F, fetch_busy, instr_F, imem_req} !== {2'b01, NOP, 1'b0})
      $display("FAIL drop_flush got=%b%b/%h/%b exp=01/%h/0", fetch_valid_F, fetch_busy, instr_F, imem_req, NOP); else passed++;
    hold_rsp = 1'b0;
    cycle();
    checks++; if ({fetch_valid_F, imem_req} !== 2'b00) $display("FAIL drop_wait got=%b/%b exp=0/0", fetch_valid_F, imem_req); else passed++;
    cycle();
    checks++; if ({fetch_valid_F, imem_req, imem_addr} !== {2'b01, 32'h100})
      $display("FAIL drop_discard got=%b/%b/%h exp=0/1/100", fetch_valid_F, imem_req, imem_addr); else passed++;
    cycle(); cycle();
    checks++; if ({PC_F, instr_F, fetch_valid_F} !== {32'h100, instr_of(32'h100), 1'b1})
      $display("FAIL drop_target got=%h/%h/%b exp=100/%h/1", PC_F, instr_F, fetch_valid_F, instr_of(32'h100)); else passed++;
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset();
    cycle(); cycle(); cycle();
    stall_F = 1'b1; PCSrc_E = 1'b1; PCTarget_E = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b0) $display("FAIL rs_req got=%b exp=0", imem_req); else passed++;
    cycle();
    stall_F = 1'b0; PCSrc_E = 1'b0;
    #1;
    checks++; if ({fetch_valid_F, instr_F, imem_req, imem_addr} !== {1'b0, NOP, 1'b1, 32'h100})
      $display("FAIL rs_flush got=%b/%h/%b/%h exp=0/%h/1/100", fetch_valid_F, instr_F, imem_req, imem_addr, NOP); else passed++;
    cycle();
    checks++; if (fetch_valid_F !== 1'b0) $display("FAIL rs_no_skid got=%b exp=0", fetch_valid_F); else passed++;
    cycle();
    checks++; if ({PC_F, instr_F, fetch_valid_F} !== {32'h100, instr_of(32'h100), 1'b1})
      $display("FAIL rs_target got=%h/%h/%b exp=100/%h/1", PC_F, instr_F, fetch_valid_F, instr_of(32'h100)); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(); cycle(); cycle();
    PCSrc_E = 1'b1; PCTarget_E = 32'hFFFF_FFFE;
    cycle();
    PCSrc_E = 1'b0;
    #1;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_addr0 got=%b/%h exp=1/fffffffc", imem_req, imem_addr); else passed++;
    cycle();
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_addr1 got=%b/%h exp=1/0", imem_req, imem_addr); else passed++;
    cycle();
    checks++; if ({PC_F, PCPlus4_F, instr_F} !== {32'hFFFF_FFFC, 32'h0, instr_of(32'hFFFF_FFFC)})
      $display("FAIL wrap_top got=%h/%h/%h exp=fffffffc/0/%h", PC_F, PCPlus4_F, instr_F, instr_of(32'hFFFF_FFFC)); else passed++;
    cycle();
    checks++; if ({PC_F, PCPlus4_F, instr_F} !== {32'h0, 32'h4, instr_of(32'h0)})
      $display("FAIL wrap_zero got=%h/%h/%h exp=0/4/%h", PC_F, PCPlus4_F, instr_F, instr_of(32'h0)); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    cycle();
    hold_rsp = 1'b1;
    cycle();
    checks++; if ({PC_F, fetch_valid_F} !== {32'h0, 1'b1}) $display("FAIL rmw_pre got=%h/%b exp=0/1", PC_F, fetch_valid_F); else passed++;
    reset = 1'b1;
    #1;
    checks++; if ({fetch_valid_F, instr_F, PC_F, PCPlus4_F, imem_req} !== {1'b0, NOP, 64'h0, 1'b0})
      $display("FAIL rmw_async got=%b/%h/%h/%h/%b exp=0/%h/0/0/0", fetch_valid_F, instr_F, PC_F, PCPlus4_F, imem_req, NOP); else passed++;
    cycle();
    reset = 1'b0; hold_rsp = 1'b0; pend = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = instr_of(32'h4);
    #1;
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL rmw_req got=%b/%h exp=1/0", imem_req, imem_addr); else passed++;
    cycle();
    imem_gnt = 1'b1;
    checks++; if (fetch_valid_F !== 1'b0) $display("FAIL rmw_stale got=%b exp=0", fetch_valid_F); else passed++;
    cycle(); cycle();
    checks++; if ({PC_F, instr_F, fetch_valid_F} !== {32'h0, instr_of(32'h0), 1'b1})
      $display("FAIL rmw_first got=%h/%h/%b exp=0/%h/1", PC_F, instr_F, fetch_valid_F, instr_of(32'h0)); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_skid();
    test_redirect_drop();
    test_redirect_rvalid_stall();
    test_wrap();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
